merger_out_packer: RTL and testbench

//  Write-side counterpart of the leaf loaders: accepts the merger tree's P-record

---
 rtl/merger_out_packer.sv | 133 +++++++++++++
 tb/tb_merger_out_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merger_out_packer.sv
// Packs P-record merger beats into LINE_WIDTH-bit memory lines and writes them to
// consecutive line addresses; the final partial line is padded with max-key sentinels.
`timescale 1ns/1ps
module merger_out_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int P          = 4,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [CNT_WIDTH-1:0]    i_num_recs,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [LINE_WIDTH-1:0]   o_wr_data,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int BEAT_W = P * DATA_WIDTH;
  localparam int BEATS  = LINE_WIDTH / BEAT_W;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] P_CNT    = CNT_WIDTH'(P);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [CNT_WIDTH-1:0]   r_rem_beats;
  logic [IDX_W-1:0]       r_beat_idx;
  logic [LINE_WIDTH-1:0]  r_line_buf;
  logic [LINE_WIDTH-1:0]  w_line_fill;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [LINE_WIDTH-1:0]  r_wr_data;
  logic                   r_wr_valid;
  logic                   w_out_free;
  logic                   w_accept;
  logic                   w_line_full;
  logic                   w_flush_emit;
  logic                   w_start;

  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_valid = r_wr_valid;

  // The output register is free if empty or being drained this cycle.
  always_comb begin
    w_out_free   = ~r_wr_valid | i_wr_ready;
    o_ready      = (r_state == S_RUN) && (r_rem_beats != '0) &&
                   !((r_beat_idx == LAST_IDX) && !w_out_free);
    w_accept     = i_valid & o_ready;
    w_line_full  = w_accept && (r_beat_idx == LAST_IDX);
    w_flush_emit = (r_state == S_FLUSH) && (r_beat_idx != '0) && w_out_free;
    w_start      = (r_state == S_IDLE) && i_start;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_DONE);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_line_fill = r_line_buf;
    w_line_fill[int'(r_beat_idx) * BEAT_W +: BEAT_W] = i_data;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (r_rem_beats == '0) w_state_next = S_FLUSH;
      S_FLUSH: if ((r_beat_idx == '0) && w_out_free) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // The line buffer idles at all-ones, so slots never written are already sentinels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem_beats <= '0;
      r_beat_idx  <= '0;
      r_line_buf  <= '1;
      r_addr      <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if (w_start) begin
        r_rem_beats <= i_num_recs / P_CNT;
        r_addr      <= i_base_addr;
        r_beat_idx  <= '0;
        r_line_buf  <= '1;
      end

      if (w_accept) begin
        r_rem_beats <= r_rem_beats - 1'b1;
        if (w_line_full) begin
          r_beat_idx <= '0;
          r_line_buf <= '1;
        end else begin
          r_beat_idx <= r_beat_idx + 1'b1;
          r_line_buf <= w_line_fill;
        end
      end

      if (w_line_full || w_flush_emit) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_addr;
        r_wr_data  <= w_line_full ? w_line_fill : r_line_buf;
        r_addr     <= r_addr + 1'b1;
        if (w_flush_emit) begin
          r_beat_idx <= '0;
          r_line_buf <= '1;
        end
      end else if (r_wr_valid && i_wr_ready) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merger_out_packer.sv
// Bench for merger_out_packer: a line-level model builds the expected write stream
// from the job parameters; a negedge monitor compares every write against it.
`timescale 1ns/1ps
module tb_merger_out_packer;
  localparam int DW  = 32;
  localparam int P   = 4;
  localparam int LW  = 512;
  localparam int AW  = 32;
  localparam int CW  = 32;
  localparam int BW  = P * DW;
  localparam int RPL = LW / DW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [CW-1:0] i_num_recs = '0;
  logic [BW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [AW-1:0] o_wr_addr;
  logic [LW-1:0] o_wr_data;
  logic          o_wr_valid;
  logic          i_wr_ready = 1'b1;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  merger_out_packer #(.DATA_WIDTH(DW), .P(P), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_recs(i_num_recs), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
    .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_done(o_done)
  );

  int  n_checks = 0;
  int  n_err = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  int  acc_beats = 0;
  int  job_beats = 0;
  int  done_cnt = 0;
  int  busy_cycles = 0;
  int  stall_left = 0;
  bit  prev_stall = 1'b0;
  wr_t held;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] beat(input logic [31:0] seed, input int b);
    logic [BW-1:0] d;
    for (int s = 0; s < P; s++) d[s*DW +: DW] = seed + 32'(b * P + s);
    return d;
  endfunction

  // Expected lines: records seed.. in order, last line topped up with all-ones keys.
  function automatic void build_exp(input logic [AW-1:0] base, input logic [CW-1:0] num,
                                    input logic [31:0] seed);
    int  nrecs;
    int  nlines;
    int  idx;
    wr_t w;
    nrecs  = int'(num / 4) * 4;
    nlines = (nrecs + RPL - 1) / RPL;
    exp_q.delete();
    for (int l = 0; l < nlines; l++) begin
      w.addr = base + AW'(l);
      for (int r = 0; r < RPL; r++) begin
        idx = l * RPL + r;
        w.data[r*DW +: DW] = (idx < nrecs) ? seed + 32'(idx) : 32'hFFFF_FFFF;
      end
      exp_q.push_back(w);
    end
  endfunction

  // Write-channel back-pressure: stays low until stall_left cycles with a pending write pass.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && o_wr_valid) stall_left--;
    i_wr_ready = (stall_left == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy) busy_cycles++;
      if (!o_busy) check("ready_when_idle", LW'(o_ready), LW'(0));
      else if (acc_beats >= job_beats) check("ready_past_count", LW'(o_ready), LW'(0));
      if (o_ready && i_valid) acc_beats++;
      if (o_wr_valid) begin
        if (prev_stall) begin
          check("hold_addr", LW'(o_wr_addr), LW'(held.addr));
          check("hold_data", o_wr_data, held.data);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_write", LW'(o_wr_valid), LW'(0));
          prev_stall = 1'b0;
        end else if (i_wr_ready) begin
          check("wr_addr", LW'(o_wr_addr), LW'(exp_q[0].addr));
          check("wr_data", o_wr_data, exp_q[0].data);
          held.addr = o_wr_addr;
          held.data = o_wr_data;
          log_q.push_back(held);
          void'(exp_q.pop_front());
          prev_stall = 1'b0;
        end else begin
          held.addr  = o_wr_addr;
          held.data  = o_wr_data;
          prev_stall = 1'b1;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (o_done) begin
        done_cnt++;
        check("done_after_writes", LW'(exp_q.size()), LW'(0));
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] base, input logic [CW-1:0] num);
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = base; i_num_recs = num;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Presents nbeats beats back to back, then optionally keeps i_valid high for extra cycles.
  task automatic feed(input logic [31:0] seed, input int nbeats, input int extra, input bit bogus);
    for (int b = 0; b < nbeats; b++) begin
      bit got;
      int waited;
      got = 1'b0;
      waited = 0;
      i_valid = 1'b1;
      i_data  = beat(seed, b);
      if (bogus && b == 1) begin
        i_start = 1'b1; i_base_addr = 32'h5; i_num_recs = 32'd8;
      end
      while (!got && waited < 200) begin
        @(negedge clk); got = o_ready;
        @(posedge clk); #1;
        waited++;
      end
      i_start = 1'b0;
      if (!got) begin
        check("beat_accepted", LW'(got), LW'(1));
        i_valid = 1'b0;
        return;
      end
    end
    i_data = beat(seed, nbeats);
    repeat (extra) begin @(posedge clk); #1; end
    i_valid = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [CW-1:0] num,
                         input logic [31:0] seed, input int extra, input bit bogus);
    build_exp(base, num, seed);
    job_beats = int'(num / 4);
    acc_beats = 0; done_cnt = 0; busy_cycles = 0;
    log_q.delete();
    start_job(base, num);
    feed(seed, job_beats, extra, bogus);
    for (int c = 0; c < 1000 && done_cnt == 0; c++) @(negedge clk);
    check("done_seen", LW'(done_cnt != 0), LW'(1));
    repeat (2) @(negedge clk);
    check("done_pulse_count", LW'(done_cnt), LW'(1));
    check("idle_after_done", LW'(o_busy), LW'(0));
    check("all_writes_seen", LW'(exp_q.size()), LW'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"},    LW'(o_ready),    LW'(0));
    check({tag, "_wr_valid"}, LW'(o_wr_valid), LW'(0));
    check({tag, "_busy"},     LW'(o_busy),     LW'(0));
    check({tag, "_done"},     LW'(o_done),     LW'(0));
    check({tag, "_wr_addr"},  LW'(o_wr_addr),  LW'(0));
    check({tag, "_wr_data"},  o_wr_data,       LW'(0));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;

    // Two full lines, records 0..31.
    run_job(32'h100, 32'd32, 32'h0, 0, 1'b0);
    check("t1_writes", LW'(log_q.size()), LW'(2));
    if (log_q.size() == 2) begin
      check("t1_addr0", LW'(log_q[0].addr), LW'(32'h100));
      check("t1_rec0",  LW'(log_q[0].data[31:0]), LW'(32'd0));
      check("t1_rec15", LW'(log_q[0].data[511:480]), LW'(32'd15));
      check("t1_addr1", LW'(log_q[1].addr), LW'(32'h101));
      check("t1_rec31", LW'(log_q[1].data[511:480]), LW'(32'd31));
    end

    // Partial final line padded with sentinels.
    run_job(32'h100, 32'd20, 32'h0, 0, 1'b0);
    check("t2_writes", LW'(log_q.size()), LW'(2));
    if (log_q.size() == 2) begin
      check("t2_rec19", LW'(log_q[1].data[127:96]),  LW'(32'd19));
      check("t2_pad20", LW'(log_q[1].data[159:128]), LW'(32'hFFFF_FFFF));
      check("t2_pad31", LW'(log_q[1].data[511:480]), LW'(32'hFFFF_FFFF));
    end

    // Write channel stalled for 10 cycles while the next line fills.
    stall_left = 10;
    fork
      run_job(32'h300, 32'd32, 32'h1000, 0, 1'b0);
      begin
        int c;
        c = 0;
        while (!(o_wr_valid && !o_ready) && c < 300) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        check("t3_ready_low", LW'(o_ready), LW'(0));
        check("t3_beats_in",  LW'(acc_beats), LW'(7));
        check("t3_addr",      LW'(o_wr_addr), LW'(32'h300));
        check("t3_rec0",      LW'(o_wr_data[31:0]), LW'(32'h1000));
      end
    join
    check("t3_writes", LW'(log_q.size()), LW'(2));

    // Empty job.
    run_job(32'h400, 32'd0, 32'h0, 0, 1'b0);
    check("t4_busy_cycles", LW'(busy_cycles), LW'(3));
    check("t4_writes", LW'(log_q.size()), LW'(0));

    // Reset in the middle of a job with a write pending.
    stall_left = 1000;
    build_exp(32'h200, 32'd32, 32'h5000);
    job_beats = 8; acc_beats = 0;
    start_job(32'h200, 32'd32);
    feed(32'h5000, 5, 0, 1'b0);
    for (int c = 0; c < 50 && !o_wr_valid; c++) @(negedge clk);
    check("t5_pending", LW'(o_wr_valid), LW'(1));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_outputs_zero("t5_reset");
    exp_q.delete();
    prev_stall = 1'b0;
    stall_left = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_job(32'h0, 32'd16, 32'h7000, 0, 1'b0);
    check("t5_writes", LW'(log_q.size()), LW'(1));
    if (log_q.size() == 1) begin
      check("t5_addr",  LW'(log_q[0].addr), LW'(32'h0));
      check("t5_rec0",  LW'(log_q[0].data[31:0]), LW'(32'h7000));
      check("t5_rec15", LW'(log_q[0].data[511:480]), LW'(32'h700F));
    end

    // Address wrap, start while busy, surplus valid beats.
    run_job(32'hFFFF_FFFF, 32'd32, 32'hA000, 20, 1'b1);
    check("t6_writes", LW'(log_q.size()), LW'(2));
    if (log_q.size() == 2) begin
      check("t6_addr0", LW'(log_q[0].addr), LW'(32'hFFFF_FFFF));
      check("t6_addr1", LW'(log_q[1].addr), LW'(32'h0));
    end
    check("t6_beats_taken", LW'(acc_beats), LW'(8));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
